// File: rtl/roi_crop_serializer.sv
// Crops an OUT_ROWS x OUT_COLS window out of a raster stream of packed-pixel beats
// and serializes the window one pixel per output handshake, left to right, top to bottom.
module roi_crop_serializer #(
  parameter int IN_ROWS  = 64,
  parameter int IN_COLS  = 64,
  parameter int OUT_ROWS = 16,
  parameter int OUT_COLS = 16,
  parameter int PIX_W    = 8,
  parameter int IN_PPB   = 32,
  parameter int OUT_W    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ap_start,
  output logic                          ap_ready,
  output logic                          ap_idle,
  output logic                          ap_done,
  input  logic [$clog2(IN_COLS)-1:0]    crop_x0,
  input  logic [$clog2(IN_ROWS)-1:0]    crop_y0,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [IN_PPB*PIX_W-1:0]       s_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [OUT_W-1:0]              m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser
);

  localparam int CW = $clog2(IN_COLS);
  localparam int RW = $clog2(IN_ROWS);
  localparam int XW = CW + 1;
  localparam int YW = RW + 1;
  localparam int IW = (IN_PPB > 1) ? $clog2(IN_PPB) : 1;

  localparam logic [CW-1:0] X_MAX    = CW'(IN_COLS - OUT_COLS);
  localparam logic [RW-1:0] Y_MAX    = RW'(IN_ROWS - OUT_ROWS);
  localparam logic [CW-1:0] COL_STEP = CW'(IN_PPB);
  localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - IN_PPB);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [OUT_W-1:0] pick_pixel(input logic [IN_PPB*PIX_W-1:0] beat,
                                                  input logic [IW-1:0] idx);
    logic [PIX_W-1:0] pix;
    pix = beat[idx*PIX_W +: PIX_W];
    return pix[PIX_W-1 -: OUT_W];
  endfunction

  state_t                    state_q, state_d;
  logic [CW-1:0]             x0c_q, x0c_d;
  logic [RW-1:0]             y0c_q, y0c_d;
  logic [RW-1:0]             row_q, row_d;
  logic [CW-1:0]             col_q, col_d;
  logic                      in_done_q, in_done_d;
  logic [IN_PPB*PIX_W-1:0]   beat_q, beat_d;
  logic [XW-1:0]             bcol_q, bcol_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [IW-1:0]             last_idx_q, last_idx_d;
  logic                      tvalid_q, tvalid_d;
  logic [OUT_W-1:0]          tdata_q, tdata_d;
  logic                      tlast_q, tlast_d;
  logic                      tuser_q, tuser_d;

  logic                      in_hs_s, out_hs_s, at_last_s, buf_free_s;
  logic                      row_in_s, hit_s;
  logic [XW-1:0]             beat_lo_s, beat_hi_s, win_lo_s, win_hi_s;
  logic [XW-1:0]             first_col_s, last_col_s, next_col_s;
  logic [IW-1:0]             first_idx_s, next_idx_s;

  // The holding buffer is the output register; it frees on the handshake of its last crop pixel.
  assign out_hs_s   = tvalid_q && m_axis_tready;
  assign at_last_s  = (idx_q == last_idx_q);
  assign buf_free_s = !tvalid_q || (out_hs_s && at_last_s);
  assign s_axis_tready = (state_q == RUN) && !in_done_q && buf_free_s;
  assign in_hs_s    = s_axis_tvalid && s_axis_tready;

  assign beat_lo_s   = {1'b0, col_q};
  assign beat_hi_s   = beat_lo_s + XW'(IN_PPB - 1);
  assign win_lo_s    = {1'b0, x0c_q};
  assign win_hi_s    = win_lo_s + XW'(OUT_COLS - 1);
  assign row_in_s    = ({1'b0, row_q} >= {1'b0, y0c_q}) &&
                       ({1'b0, row_q} < ({1'b0, y0c_q} + YW'(OUT_ROWS)));
  assign hit_s       = row_in_s && (beat_lo_s <= win_hi_s) && (beat_hi_s >= win_lo_s);
  assign first_col_s = (beat_lo_s > win_lo_s) ? beat_lo_s : win_lo_s;
  assign last_col_s  = (beat_hi_s < win_hi_s) ? beat_hi_s : win_hi_s;
  assign first_idx_s = IW'(first_col_s - beat_lo_s);
  assign next_idx_s  = idx_q + IW'(1);
  assign next_col_s  = bcol_q + XW'(next_idx_s);

  assign ap_idle  = (state_q == IDLE);
  assign ap_done  = (state_q == DONE);
  assign ap_ready = (state_q == IDLE) && ap_start;

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;

  // Next-state logic: frame control, input raster counters and output pixel selection.
  always_comb begin
    state_d    = state_q;
    x0c_d      = x0c_q;
    y0c_d      = y0c_q;
    row_d      = row_q;
    col_d      = col_q;
    in_done_d  = in_done_q;
    beat_d     = beat_q;
    bcol_d     = bcol_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    tuser_d    = tuser_q;
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          state_d   = RUN;
          x0c_d     = (crop_x0 > X_MAX) ? X_MAX : crop_x0;
          y0c_d     = (crop_y0 > Y_MAX) ? Y_MAX : crop_y0;
          row_d     = '0;
          col_d     = '0;
          in_done_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (in_hs_s) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d     = '0;
              in_done_d = 1'b1;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + COL_STEP;
          end
        end else begin
          col_d = col_q;
        end
        // Beats with no crop pixel pass straight through without touching the buffer.
        if (in_hs_s && hit_s) begin
          beat_d     = s_axis_tdata;
          bcol_d     = beat_lo_s;
          idx_d      = first_idx_s;
          last_idx_d = IW'(last_col_s - beat_lo_s);
          tvalid_d   = 1'b1;
          tdata_d    = pick_pixel(s_axis_tdata, first_idx_s);
          tlast_d    = (first_col_s == win_hi_s);
          tuser_d    = (row_q == y0c_q) && (first_col_s == win_lo_s);
        end else if (out_hs_s) begin
          if (at_last_s) begin
            tvalid_d = 1'b0;
          end else begin
            idx_d   = next_idx_s;
            tdata_d = pick_pixel(beat_q, next_idx_s);
            tlast_d = (next_col_s == win_hi_s);
            tuser_d = 1'b0;
          end
        end else begin
          tvalid_d = tvalid_q;
        end
        if (in_done_d && !tvalid_d) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      x0c_q      <= '0;
      y0c_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      in_done_q  <= 1'b0;
      beat_q     <= '0;
      bcol_q     <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0c_q      <= x0c_d;
      y0c_q      <= y0c_d;
      row_q      <= row_d;
      col_q      <= col_d;
      in_done_q  <= in_done_d;
      beat_q     <= beat_d;
      bcol_q     <= bcol_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
    end
  end

endmodule

// File: tb/tb_roi_crop_serializer.sv
// Scoreboard bench for roi_crop_serializer: a default 8-bit instance and a 12-bit-pixel
// instance share stimulus; expected crop pixels come from a frame-array reference model.
module tb_roi_crop_serializer;

  localparam int R = 64, C = 64, ORW = 16, OCL = 16, PPB = 32;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             ap_start, s_tvalid, m_tready;
  logic [5:0]       crop_x0, crop_y0;
  logic [PPB*8-1:0] s_tdata8;
  logic [PPB*12-1:0] s_tdata12;

  logic ap_ready_a, ap_idle_a, ap_done_a, s_tready_a, m_tvalid_a, m_tlast_a, m_tuser_a;
  logic ap_ready_b, ap_idle_b, ap_done_b, s_tready_b, m_tvalid_b, m_tlast_b, m_tuser_b;
  logic [7:0] m_tdata_a, m_tdata_b;

  roi_crop_serializer dut_a (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready_a), .ap_idle(ap_idle_a),
    .ap_done(ap_done_a), .crop_x0(crop_x0), .crop_y0(crop_y0), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready_a), .s_axis_tdata(s_tdata8), .m_axis_tvalid(m_tvalid_a),
    .m_axis_tready(m_tready), .m_axis_tdata(m_tdata_a), .m_axis_tlast(m_tlast_a),
    .m_axis_tuser(m_tuser_a));

  roi_crop_serializer #(.PIX_W(12), .OUT_W(8)) dut_b (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready_b), .ap_idle(ap_idle_b),
    .ap_done(ap_done_b), .crop_x0(crop_x0), .crop_y0(crop_y0), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready_b), .s_axis_tdata(s_tdata12), .m_axis_tvalid(m_tvalid_b),
    .m_axis_tready(m_tready), .m_axis_tdata(m_tdata_b), .m_axis_tlast(m_tlast_b),
    .m_axis_tuser(m_tuser_b));

  int checks = 0;
  int failures = 0;
  exp_t q[2][$];
  bit   hold[2];
  logic [9:0] held[2];
  int   pcnt[2];
  int   lcnt[2];
  int   done_cnt = 0;
  bit   rand_ready = 1'b0;
  logic [7:0] pv[R][C];
  logic [3:0] pn[R][C];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic r, input logic [7:0] d,
                     input logic l, input logic u);
    exp_t e;
    if (hold[k]) begin
      check($sformatf("stall_stable%0d", k), {21'd0, v, d, l, u}, {21'd0, 1'b1, held[k]});
      hold[k] = 1'b0;
    end
    if (v && r) begin
      pcnt[k]++;
      if (l) lcnt[k]++;
      if (q[k].size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_pixel%0d actual=%0h required=none", k, d);
      end else begin
        e = q[k].pop_front();
        check($sformatf("pixel%0d", k), {22'd0, d, l, u}, {22'd0, e.d, e.l, e.u});
      end
    end else if (v) begin
      hold[k] = 1'b1;
      held[k] = {d, l, u};
    end
  endtask

  // Output monitor: pops the scoreboard on every output handshake of both instances.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      mon(0, m_tvalid_a, m_tready, m_tdata_a, m_tlast_a, m_tuser_a);
      mon(1, m_tvalid_b, m_tready, m_tdata_b, m_tlast_b, m_tuser_b);
      if (ap_done_a) done_cnt++;
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(negedge clk);
      m_tready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_idle"},   ap_idle_a, 1);
    check({tag, "_ready"},  ap_ready_a, 0);
    check({tag, "_done"},   ap_done_a, 0);
    check({tag, "_stready"}, s_tready_a, 0);
    check({tag, "_mvalid"}, {m_tvalid_a, m_tvalid_b}, 0);
    check({tag, "_mside"},  {m_tlast_a, m_tuser_a}, 0);
    check({tag, "_mdata"},  m_tdata_a, 0);
  endtask

  // Runs one frame; returns early (without waiting for done) once abort_at pixels were emitted.
  task automatic run_frame(input int x0, input int y0, input bit rnd, input bit rdy, input int abort_at);
    int xc, yc, base, n;
    bit hit, aborted, extra;
    rand_ready = rdy;
    xc = (x0 > C - OCL) ? C - OCL : x0;
    yc = (y0 > R - ORW) ? R - ORW : y0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        pv[r][c] = rnd ? 8'($urandom) : 8'((r + c) & 255);
        pn[r][c] = 4'($urandom);
      end
    for (int r = yc; r < yc + ORW; r++)
      for (int c = xc; c < xc + OCL; c++) begin
        q[0].push_back('{d: pv[r][c], l: (c == xc + OCL - 1), u: (r == yc && c == xc)});
        q[1].push_back('{d: pv[r][c], l: (c == xc + OCL - 1), u: (r == yc && c == xc)});
      end
    pcnt[0] = 0; pcnt[1] = 0; lcnt[0] = 0; lcnt[1] = 0;
    base = done_cnt;
    aborted = 1'b0;
    @(negedge clk);
    crop_x0 = 6'(x0); crop_y0 = 6'(y0); ap_start = 1'b1;
    #1;
    check("ap_ready_pulse", ap_ready_a, 1);
    @(negedge clk);
    crop_x0 = 6'($urandom); crop_y0 = 6'($urandom);
    #1;
    check("start_ignored_in_run", {ap_ready_a, ap_idle_a}, 0);
    @(negedge clk);
    ap_start = 1'b0;
    for (int r = 0; r < R && !aborted; r++)
      for (int b = 0; b < C / PPB && !aborted; b++) begin
        if (rnd && $urandom_range(3, 0) == 0) @(negedge clk);
        for (int i = 0; i < PPB; i++) begin
          s_tdata8[i*8 +: 8]   = pv[r][b*PPB+i];
          s_tdata12[i*12 +: 12] = {pv[r][b*PPB+i], pn[r][b*PPB+i]};
        end
        s_tvalid = 1'b1;
        n = 0;
        #1;
        while (!s_tready_a && !aborted) begin
          @(negedge clk);
          #1;
          n++;
          if (abort_at > 0 && pcnt[0] >= abort_at) aborted = 1'b1;
          if (n > 2000) begin
            checks++; failures++; aborted = 1'b1;
            $display("FAIL beat_accept_timeout actual=%0d required=<=2000", n);
          end
        end
        if (!aborted) begin
          hit = (r >= yc) && (r < yc + ORW) && (b*PPB <= xc + OCL - 1) && (b*PPB + PPB - 1 >= xc);
          @(negedge clk);
          s_tvalid = 1'b0;
          #1;
          check("first_pixel_latency", m_tvalid_a, hit);
          if (abort_at > 0 && pcnt[0] >= abort_at) aborted = 1'b1;
        end
      end
    if (aborted) begin
      s_tvalid = 1'b0;
      return;
    end
    s_tvalid = 1'b1;
    extra = 1'b0;
    n = 0;
    while (done_cnt == base && n < 3000) begin
      @(negedge clk);
      #1;
      if (s_tready_a) extra = 1'b1;
      n++;
    end
    s_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("no_accept_after_frame", extra, 0);
    check("done_pulses", done_cnt - base, 1);
    check("pixel_count", pcnt[0], ORW * OCL);
    check("pixel_count12", pcnt[1], ORW * OCL);
    check("tlast_count", lcnt[0], ORW);
    check("scoreboard_empty", q[0].size() + q[1].size(), 0);
    check("idle_after_frame", ap_idle_a, 1);
  endtask

  initial begin
    int base;
    bit acc;
    reset = 1'b1; ap_start = 1'b0; s_tvalid = 1'b0; crop_x0 = '0; crop_y0 = '0;
    s_tdata8 = '0; s_tdata12 = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("in_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_vals("after_reset");

    run_frame(8, 4, 1'b0, 1'b0, 0);
    run_frame(24, 0, 1'b0, 1'b0, 0);
    run_frame(60, 60, 1'b0, 1'b0, 0);
    run_frame(8, 4, 1'b0, 1'b1, 0);
    for (int i = 0; i < 4; i++)
      run_frame(int'($urandom_range(63, 0)), int'($urandom_range(63, 0)), 1'b1, 1'b1, 0);

    base = done_cnt;
    run_frame(8, 4, 1'b0, 1'b0, 100);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("mid_frame_reset");
    repeat (2) @(negedge clk);
    q[0].delete(); q[1].delete();
    hold[0] = 1'b0; hold[1] = 1'b0;
    reset = 1'b0;
    check("no_done_on_abort", done_cnt - base, 0);
    s_tvalid = 1'b1;
    acc = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (s_tready_a || m_tvalid_a) acc = 1'b1;
    end
    s_tvalid = 1'b0;
    check("needs_fresh_start", acc, 0);
    run_frame(8, 4, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/roi_crop_serializer.md
ROI_CROP_SERIALIZER -- requirements
Module: roi_crop_serializer

Interface
REQ-001 SHALL have parameter IN_ROWS, default 64: input frame height in pixels.
REQ-002 SHALL have parameter IN_COLS, default 64: input frame width in pixels; must be a multiple of IN_PPB.
REQ-003 SHALL have parameter OUT_ROWS, default 16: crop window height in pixels.
REQ-004 SHALL have parameter OUT_COLS, default 16: crop window width in pixels.
REQ-005 SHALL have parameter PIX_W, default 8: input pixel width; legal values 8, 10, 12, 16.
REQ-006 SHALL have parameter IN_PPB, default 32: pixels per input beat.
REQ-007 SHALL have parameter OUT_W, default 8: output pixel width; must satisfy OUT_W<=PIX_W.
REQ-008 clk  in  1  clock.
REQ-009 reset  in  1  reset, asynchronous, active-high.
REQ-010 ap_start  in  1  start request for one frame.
REQ-011 ap_ready  out  1  one-cycle pulse when the crop coordinates are latched.
REQ-012 ap_idle  out  1  high in state IDLE.
REQ-013 ap_done  out  1  one-cycle pulse after the last crop pixel handshake.
REQ-014 crop_x0  in  $clog2(IN_COLS)  crop left column.
REQ-015 crop_y0  in  $clog2(IN_ROWS)  crop top row.
REQ-016 s_axis_tvalid  in  1; s_axis_tready  out  1; s_axis_tdata  in  IN_PPB*PIX_W  packed pixels.
REQ-017 m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tdata  out  OUT_W  one pixel.
REQ-018 m_axis_tlast  out  1  last pixel of each crop row; m_axis_tuser  out  1  first pixel of frame.

Function
REQ-019 Input pixel i of a beat SHALL occupy bits [i*PIX_W +: PIX_W]; i=0 is the leftmost column; beats arrive raster order, row-major.
REQ-020 The FSM SHALL have states IDLE, RUN and DONE.
REQ-021 IDLE to RUN SHALL occur on ap_start=1, latching the clamped coordinates and pulsing ap_ready in the same cycle.
REQ-022 Clamping: x0c=min(crop_x0, IN_COLS-OUT_COLS); y0c=min(crop_y0, IN_ROWS-OUT_ROWS).
REQ-023 RUN to DONE SHALL occur after the final input beat of the frame is accepted and the last crop pixel is handshaken.
REQ-024 DONE SHALL pulse ap_done for one cycle and then return to IDLE.
REQ-025 ap_start SHALL be ignored outside IDLE; crop_x0/crop_y0 changes after latching SHALL have no effect on the current frame.
REQ-026 s_axis_tready SHALL be high only in RUN, and only while the one-beat holding buffer is empty.
REQ-027 Beat handling:
- A beat with no pixel inside the crop window SHALL be consumed without loading the buffer, sustaining 1 beat/cycle.
- A beat with crop pixels SHALL be loaded into the buffer.
REQ-028 Buffered crop pixels SHALL be emitted left to right, one per m_axis handshake; the buffer SHALL free in the cycle its last crop pixel handshakes.
REQ-029 The first crop pixel of a loaded beat SHALL appear on m_axis one cycle after the beat is accepted.
REQ-030 m_axis_tdata SHALL be pixel[PIX_W-1 -: OUT_W] (MSB truncation).
REQ-031 m_axis_tvalid, tdata, tlast and tuser SHALL remain stable while tvalid=1 and tready=0.
REQ-032 Input row/column counters SHALL be $clog2 sized; column SHALL wrap at IN_COLS, and the row SHALL increment on column wrap.
REQ-033 After IN_ROWS*IN_COLS/IN_PPB beats, the block SHALL deassert s_axis_tready until the next frame.
REQ-034 A crop window straddling a beat boundary SHALL be emitted correctly from consecutive beats with no gap in pixel order.
REQ-035 Exactly OUT_ROWS*OUT_COLS pixels SHALL be emitted per frame, with tlast asserted exactly OUT_ROWS times.

Reset
REQ-036 On reset:
- State SHALL be IDLE, with the buffer and counters cleared.
- ap_idle SHALL be 1.
- ap_ready, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tlast and m_axis_tuser SHALL be 0; m_axis_tdata SHALL be 0.
REQ-037 Reset asserted mid-frame SHALL abort the frame immediately with no ap_done; the next frame SHALL require a fresh ap_start.

Verification
REQ-038 Baseline (defaults, pixel value = (row+col)&0xFF): start with x0=8, y0=4, tready=1 -> 256 pixels, first=12, tlast every 16th, ap_done once.
REQ-039 Beat straddle: x0=24, 16-wide window -> row 0 emits 24..39 in order across two beats, with no duplication.
REQ-040 Clamp: x0=60, y0=60 -> window at x0c=48, y0c=48; first pixel=96.
REQ-041 Backpressure: random m_axis_tready (50%) -> identical sequence to REQ-038, outputs stable while stalled.
REQ-042 Width variant: PIX_W=12, OUT_W=8, pixel 0xABC -> output 0xAB.
REQ-043 Reset at pixel 100 of a frame -> all outputs at reset values, ap_idle=1; next frame correct from pixel 0.
